// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle MIPS main control sequencer (optional addi path: MC_ADDI_EN)
module mc_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       instr_done
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXECUTE   = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
`ifdef MC_ADDI_EN
    , S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
`endif
  } state_t;

  state_t st;

  assign state = st;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      illegal_op <= 1'b0;
    end else begin
      illegal_op <= 1'b0;
      case (st)
        S_IDLE:      st <= S_FETCH;
        S_FETCH:     if (mem_ready) st <= S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: st <= S_MEM_ADDR;
            OP_RTYPE:     st <= S_EXECUTE;
            OP_BEQ:       st <= S_BRANCH;
            OP_J:         st <= S_JUMP;
`ifdef MC_ADDI_EN
            OP_ADDI:      st <= S_ADDI_EXEC;
`endif
            default: begin
              st         <= S_FETCH;
              illegal_op <= 1'b1;
            end
          endcase
        end
        S_MEM_ADDR:  st <= (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
        S_MEM_READ:  if (mem_ready) st <= S_MEM_WB;
        S_MEM_WB:    st <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) st <= S_FETCH;
        S_EXECUTE:   st <= S_R_WB;
        S_R_WB:      st <= S_FETCH;
        S_BRANCH:    st <= S_FETCH;
        S_JUMP:      st <= S_FETCH;
`ifdef MC_ADDI_EN
        S_ADDI_EXEC: st <= S_ADDI_WB;
        S_ADDI_WB:   st <= S_FETCH;
`endif
        // unreachable encodings recover through IDLE
        default:     st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    case (st)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:    alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'b10;
        instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - scoreboard bench for mc_control_fsm with route-based reference model
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       illegal_op, instr_done;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .state(state), .illegal_op(illegal_op),
    .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       ill;
    logic       done;
    logic       pcw;
    logic       pcwc;
    logic       iord;
    logic       mrd;
    logic       mwr;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic       srca;
    logic [1:0] srcb;
    logic [1:0] aop;
    logic [1:0] pcs;
  } outs_t;

  outs_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  bit    ill_pending = 0;
  bit    final_chk = 0;
  int    route_st[$];
  bit    route_mr[$];

  // Expected strobes for one cycle, straight from the per-state output table.
  function automatic outs_t model(int s, bit mr, bit ill);
    outs_t o;
    o = '0;
    o.st  = s[3:0];
    o.ill = ill;
    case (s)
      1:  begin o.mrd = 1; o.srcb = 2'b01; o.irw = mr; o.pcw = mr; end
      2:  o.srcb = 2'b11;
      3:  begin o.srca = 1; o.srcb = 2'b10; end
      4:  begin o.mrd = 1; o.iord = 1; end
      5:  begin o.rw = 1; o.m2r = 1; o.done = 1; end
      6:  begin o.mwr = 1; o.iord = 1; o.done = mr; end
      7:  begin o.srca = 1; o.aop = 2'b10; end
      8:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
      9:  begin o.srca = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; o.done = 1; end
      10: begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
      11: begin o.srca = 1; o.srcb = 2'b10; end
      12: begin o.rw = 1; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic add(int s);
    route_st.push_back(s);
    route_mr.push_back(1'($urandom_range(0, 1)));
  endtask

  task automatic add_mem(int s, int waits);
    for (int k = 0; k < waits; k++) begin
      route_st.push_back(s);
      route_mr.push_back(1'b0);
    end
    route_st.push_back(s);
    route_mr.push_back(1'b1);
  endtask

  task automatic cyc_drive(bit r, logic [5:0] op, bit mr, int s);
    @(posedge clk);
    #1;
    rst_n     = r;
    opcode    = op;
    mem_ready = mr;
    exp_q.push_back(model(s, mr, ill_pending));
    ill_pending = 0;
  endtask

  // Builds the instruction's state route, then plays it cycle by cycle.
  task automatic run_instr(logic [5:0] op, int wf, int wm, int abort_at);
    bit legal;
    bit aborted;
    route_st.delete();
    route_mr.delete();
    add_mem(1, wf);
    add(2);
    legal = 1;
    case (op)
      6'b100011: begin add(3); add_mem(4, wm); add(5); end
      6'b101011: begin add(3); add_mem(6, wm); end
      6'b000000: begin add(7); add(8); end
      6'b000100: add(9);
      6'b000010: add(10);
`ifdef MC_ADDI_EN
      6'b001000: begin add(11); add(12); end
`endif
      default: legal = 0;
    endcase
    aborted = 0;
    for (int i = 0; i < route_st.size(); i++) begin
      cyc_drive((i == abort_at) ? 1'b0 : 1'b1, op, route_mr[i], route_st[i]);
      if (i == abort_at) begin
        aborted = 1;
        break;
      end
    end
    if (aborted)
      cyc_drive(1'b1, op, 1'($urandom_range(0, 1)), 0);
    else if (!legal)
      ill_pending = 1;
  endtask

  always @(negedge clk) begin
    outs_t act;
    outs_t e;
    cyc++;
    act = {state, illegal_op, instr_done, pc_write, pc_write_cond, i_or_d,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source};
    if (final_chk) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL scoreboard_drain: leftover=%0d required=0", exp_q.size());
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL cycle%0d outputs: state act=%0d exp=%0d vec act=%h exp=%h",
                 cyc, act.st, e.st, act, e);
      end
    end
  end

  initial begin
    logic [5:0] ops [0:6];
    logic [5:0] op;
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    ops[6] = 6'b111111;

    cyc_drive(1'b0, 6'd0, 1'b0, 0);
    cyc_drive(1'b1, 6'd0, 1'b1, 0);

    run_instr(6'b000000, 0, 0, -1);
    run_instr(6'b100011, 0, 2, -1);
    run_instr(6'b000100, 0, 0, -1);
    run_instr(6'b000010, 0, 0, -1);
    run_instr(6'b111111, 0, 0, -1);
    run_instr(6'b001000, 0, 0, -1);
    run_instr(6'b101011, 1, 2, 5);
    run_instr(6'b001000, 2, 0, -1);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 7) op = 6'($urandom);
      else op = ops[$urandom_range(0, 6)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : -1);
    end

    @(posedge clk);
    #1;
    final_chk = 1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
